// File: rtl/adder_acc.sv
// Registered add/sub/accumulate/load unit with carry/borrow, sticky overflow and optional saturation.
// One-cycle latency through a single output register; in_ready = !out_valid || out_ready.
module adder_acc #(
  parameter int unsigned WIDTH = 4,
  parameter bit          SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,
    MODE_ACC  = 2'd2,
    MODE_LOAD = 2'd3
  } mode_e;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  mode_e            op;
  logic             accept;
  logic [WIDTH-1:0] add_rhs;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic             sub_borrow;

  assign op       = mode_e'(mode);
  assign in_ready = (state_q == ST_EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;

  // Add and accumulate share one adder; only the second operand differs.
  assign add_rhs    = (op == MODE_ACC) ? acc_q : b;
  assign add_sum    = {1'b0, a} + {1'b0, add_rhs};
  assign sub_diff   = a - b;
  assign sub_borrow = (a < b);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cout_d  = cout_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (accept) begin
      state_d = ST_FULL;
      case (op)
        MODE_ADD, MODE_ACC: begin
          cout_d = add_sum[WIDTH];
          q_d    = (SAT && add_sum[WIDTH]) ? ALL_ONES : add_sum[WIDTH-1:0];
        end
        MODE_SUB: begin
          cout_d = sub_borrow;
          q_d    = (SAT && sub_borrow) ? '0 : sub_diff;
        end
        MODE_LOAD: begin
          cout_d = 1'b0;
          q_d    = a;
        end
      endcase
      // Accumulator tracks the delivered (possibly saturated) result.
      if (op == MODE_ACC) begin
        acc_d = q_d;
      end
      if (op == MODE_LOAD) begin
        acc_d = a;
        ovf_d = 1'b0;
      end else begin
        ovf_d = ovf_q | cout_d;
      end
    end else if (out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      q_q     <= '0;
      cout_q  <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cout_q  <= cout_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign q         = q_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // A stalled result must not change underneath the consumer.
  hold_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(q) && $stable(cout)));

endmodule

// File: tb/tb_adder_acc.sv
// Directed bench for adder_acc: three instances (W4 wrap, W4 saturate, W8 wrap) against an integer model.
module tb_adder_acc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] in_vld = 3'b000;
  logic [7:0] a8 = 8'h00;
  logic [7:0] b8 = 8'h00;
  logic [1:0] mode = 2'd0;
  logic       out_ready = 1'b1;

  logic       rdy0, rdy1, rdy2;
  logic       vld0, vld1, vld2;
  logic [3:0] q0, q1;
  logic [7:0] q2;
  logic       c0, c1, c2;
  logic       ov0, ov1, ov2;

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  always #5 clk = ~clk;

  adder_acc #(.WIDTH(4), .SAT(1'b0)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_vld[0]), .in_ready(rdy0),
    .a(a8[3:0]), .b(b8[3:0]), .mode(mode), .out_valid(vld0), .out_ready(out_ready),
    .q(q0), .cout(c0), .ovf(ov0));

  adder_acc #(.WIDTH(4), .SAT(1'b1)) u_w4s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_vld[1]), .in_ready(rdy1),
    .a(a8[3:0]), .b(b8[3:0]), .mode(mode), .out_valid(vld1), .out_ready(out_ready),
    .q(q1), .cout(c1), .ovf(ov1));

  adder_acc #(.WIDTH(8), .SAT(1'b0)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_vld[2]), .in_ready(rdy2),
    .a(a8), .b(b8), .mode(mode), .out_valid(vld2), .out_ready(out_ready),
    .q(q2), .cout(c2), .ovf(ov2));

  int o_q[3], o_c[3], o_ov[3], o_vld[3], o_rdy[3];
  always_comb begin
    o_q[0] = int'(q0);   o_q[1] = int'(q1);   o_q[2] = int'(q2);
    o_c[0] = int'(c0);   o_c[1] = int'(c1);   o_c[2] = int'(c2);
    o_ov[0] = int'(ov0); o_ov[1] = int'(ov1); o_ov[2] = int'(ov2);
    o_vld[0] = int'(vld0); o_vld[1] = int'(vld1); o_vld[2] = int'(vld2);
    o_rdy[0] = int'(rdy0); o_rdy[1] = int'(rdy1); o_rdy[2] = int'(rdy2);
  end

  // Reference model: plain integer arithmetic per instance.
  int m_vld[3] = '{0, 0, 0};
  int m_q[3]   = '{0, 0, 0};
  int m_c[3]   = '{0, 0, 0};
  int m_ov[3]  = '{0, 0, 0};
  int m_acc[3] = '{0, 0, 0};
  int m_w[3]   = '{4, 4, 8};
  int m_sat[3] = '{0, 1, 0};

  always @(posedge clk or negedge rst_n) begin : model
    int mx, av, bv, full, cy, res;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_vld[i] = 0; m_q[i] = 0; m_c[i] = 0; m_ov[i] = 0; m_acc[i] = 0;
      end else if (in_vld[i] && (m_vld[i] == 0 || out_ready)) begin
        mx = (1 << m_w[i]) - 1;
        av = int'(a8) & mx;
        bv = int'(b8) & mx;
        case (mode)
          2'd0: begin full = av + bv;        cy = (full > mx) ? 1 : 0; end
          2'd1: begin full = av - bv;        cy = (av < bv) ? 1 : 0;   end
          2'd2: begin full = m_acc[i] + av;  cy = (full > mx) ? 1 : 0; end
          default: begin full = av;          cy = 0;                   end
        endcase
        if (m_sat[i] != 0 && cy != 0) res = (mode == 2'd1) ? 0 : mx;
        else res = full & mx;
        if (mode == 2'd2) m_acc[i] = res;
        if (mode == 2'd3) begin
          m_acc[i] = av;
          m_ov[i]  = 0;
        end else begin
          m_ov[i] = m_ov[i] | cy;
        end
        m_q[i] = res; m_c[i] = cy; m_vld[i] = 1;
      end else if (out_ready) begin
        m_vld[i] = 0;
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("u%0d.out_valid", i), o_vld[i], m_vld[i]);
        check($sformatf("u%0d.in_ready", i), o_rdy[i], (m_vld[i] == 0 || out_ready) ? 1 : 0);
        check($sformatf("u%0d.ovf", i), o_ov[i], m_ov[i]);
        if (m_vld[i] != 0) begin
          check($sformatf("u%0d.q", i), o_q[i], m_q[i]);
          check($sformatf("u%0d.cout", i), o_c[i], m_c[i]);
        end
      end
    end
  end

  // One beat with out_ready=1; checks the literal result right after the accepting edge.
  task automatic beat(input int idx, input int md, input int av, input int bv,
                      input int eq, input int ec, input int eo, input string nm);
    in_vld = 3'b000;
    in_vld[idx] = 1'b1;
    mode = md[1:0];
    a8 = av[7:0];
    b8 = bv[7:0];
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_vld = 3'b000;
    check({nm, ".vld"}, o_vld[idx], 1);
    check({nm, ".q"}, o_q[idx], eq);
    check({nm, ".cout"}, o_c[idx], ec);
    check({nm, ".ovf"}, o_ov[idx], eo);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst.u%0d.vld", i), o_vld[i], 0);
      check($sformatf("rst.u%0d.q", i), o_q[i], 0);
      check($sformatf("rst.u%0d.cout", i), o_c[i], 0);
      check($sformatf("rst.u%0d.ovf", i), o_ov[i], 0);
      check($sformatf("rst.u%0d.rdy", i), o_rdy[i], 1);
    end
    rst_n = 1'b1;

    beat(0, 0, 'h0, 'h0, 'h0, 0, 0, "add00");
    beat(0, 0, 'h5, 'ha, 'hf, 0, 0, "add5a");
    beat(0, 0, 'h7, 'ha, 'h1, 1, 1, "add7a");
    beat(0, 0, 'h1, 'hf, 'h0, 1, 1, "add1f");
    beat(0, 0, 'hf, 'hf, 'he, 1, 1, "addff");

    beat(1, 0, 'h7, 'ha, 'hf, 1, 1, "sat_add7a");
    beat(1, 0, 'hf, 'hf, 'hf, 1, 1, "sat_addff");
    beat(1, 1, 'h3, 'h5, 'h0, 1, 1, "sat_sub35");
    beat(1, 1, 'h5, 'h3, 'h2, 0, 1, "sat_sub53");

    beat(0, 3, 'h2, 'h0, 'h2, 0, 0, "load2");
    beat(0, 2, 'h3, 'hf, 'h5, 0, 0, "acc3");
    beat(0, 2, 'h4, 'hf, 'h9, 0, 0, "acc4");
    beat(0, 2, 'h9, 'hf, 'h2, 1, 1, "acc9");
    beat(0, 3, 'h0, 'h0, 'h0, 0, 0, "load0");

    beat(1, 3, 'h2, 'h0, 'h2, 0, 0, "sat_load2");
    beat(1, 2, 'hf, 'h0, 'hf, 1, 1, "sat_accf");
    beat(1, 2, 'h1, 'h0, 'hf, 1, 1, "sat_acc1");
    beat(1, 2, 'h0, 'h0, 'hf, 0, 1, "sat_acc0");

    // Back-pressure: first beat lands, second waits while out_ready is low.
    in_vld = 3'b001; mode = 2'd0; a8 = 8'h1; b8 = 8'h2; out_ready = 1'b0;
    @(posedge clk);
    #1;
    a8 = 8'h3; b8 = 8'h4;
    for (int k = 0; k < 3; k++) begin
      check("bp.vld", o_vld[0], 1);
      check("bp.q", o_q[0], 3);
      check("bp.rdy", o_rdy[0], 0);
      @(posedge clk);
      #1;
    end
    check("bp.q_held", o_q[0], 3);
    out_ready = 1'b1;
    #1;
    check("bp.rdy_up", o_rdy[0], 1);
    @(posedge clk);
    #1;
    in_vld = 3'b000;
    check("bp.q2", o_q[0], 7);
    check("bp.vld2", o_vld[0], 1);

    // Reset while holding a result with acc=9, ovf=1.
    beat(0, 3, 'h5, 'h0, 'h5, 0, 0, "pre_load5");
    beat(0, 2, 'hf, 'h0, 'h4, 1, 1, "pre_accf");
    beat(0, 2, 'h5, 'h0, 'h9, 0, 1, "pre_acc5");
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst.q", o_q[0], 0);
    check("mid_rst.cout", o_c[0], 0);
    check("mid_rst.ovf", o_ov[0], 0);
    check("mid_rst.vld", o_vld[0], 0);
    check("mid_rst.rdy", o_rdy[0], 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    beat(0, 2, 'h1, 'h0, 'h1, 0, 0, "post_rst_acc1");

    beat(2, 0, 'hff, 'h01, 'h00, 1, 1, "w8_addff01");
    beat(2, 0, 'h80, 'h7f, 'hff, 0, 1, "w8_add807f");
    beat(2, 1, 'h00, 'h01, 'hff, 1, 1, "w8_sub0001");

    repeat (3) @(posedge clk);
    #1;
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
